// File: rtl/cond_logic.sv
// ----------------------------------------------------------------------------
// cond_logic -- execute-stage conditional-execution unit.
//
// Holds the architectural NZCV flag register and feeds it to the condition
// checker. Uses the checker's CondEx result to gate the decoder's
// write/branch intents, then registers them for the memory stage. After a
// taken branch, a small shadow FSM squashes the next SHADOW_SLOTS pipeline
// advances, which carry wrong-path instructions.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-low reset
//   en         in   pipeline advance (0 = stall, all state holds)
//   flush      in   synchronous flush from the hazard unit
//   InstrValid in   execute stage holds a real instruction
//   CondEx     in   condition result for the current instruction
//   ALUFlags   in   {N,Z,C,V} from the ALU
//   FlagW      in   [1] write N,Z ; [0] write C,V
//   PCS        in   instruction writes the PC
//   RegW       in   instruction writes the register file
//   MemW       in   instruction writes memory
//   NoWrite    in   compare-type instruction, suppresses RegW
//   Flags      out  registered {N,Z,C,V}
//   PCSrcM     out  registered taken branch
//   RegWriteM  out  registered register-file write enable
//   MemWriteM  out  registered memory write enable
//   Squash     out  combinational, current execute instruction is killed
// ----------------------------------------------------------------------------
module cond_logic #(
    parameter int SHADOW_SLOTS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       flush,
    input  logic       InstrValid,
    input  logic       CondEx,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       NoWrite,
    output logic [3:0] Flags,
    output logic       PCSrcM,
    output logic       RegWriteM,
    output logic       MemWriteM,
    output logic       Squash
);

    // A zero-slot configuration still needs a legal one-bit counter.
    localparam int              CNT_W     = (SHADOW_SLOTS > 0) ? $clog2(SHADOW_SLOTS + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SHADOW_SLOTS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam bit              SHADOW_EN = (SHADOW_SLOTS > 0);

    typedef enum logic {IDLE = 1'b0, SHADOW = 1'b1} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             exec_p0;
    logic             take_p0;
    logic             adv_p0;

    assign exec_p0 = InstrValid & CondEx & ~Squash;
    assign adv_p0  = en & ~flush;
    assign take_p0 = adv_p0 & exec_p0 & PCS & SHADOW_EN;

    // ---- execute -> memory stage boundary ----------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Flags     <= 4'b0000;
            PCSrcM    <= 1'b0;
            RegWriteM <= 1'b0;
            MemWriteM <= 1'b0;
        end else if (flush) begin
            // Flush clears the outgoing intents but never touches the flags.
            PCSrcM    <= 1'b0;
            RegWriteM <= 1'b0;
            MemWriteM <= 1'b0;
        end else if (en) begin
            if (exec_p0 && FlagW[1]) Flags[3:2] <= ALUFlags[3:2];
            if (exec_p0 && FlagW[0]) Flags[1:0] <= ALUFlags[1:0];
            PCSrcM    <= exec_p0 & PCS;
            RegWriteM <= exec_p0 & RegW & ~NoWrite;
            MemWriteM <= exec_p0 & MemW;
        end
    end

    // Shadow FSM: state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Shadow FSM: next state. The counter tracks pipeline advances, not
    // valid instructions, so bubbles inside the shadow still consume slots.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (flush) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (take_p0) begin
                        state_next = SHADOW;
                        cnt_next   = CNT_LOAD;
                    end
                end
                SHADOW: begin
                    if (en) begin
                        if (cnt == CNT_ONE) begin
                            state_next = IDLE;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt - CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Shadow FSM: outputs.
    always_comb begin
        Squash = 1'b0;
        if (state == SHADOW) Squash = 1'b1;
    end

endmodule

// File: tb/tb_cond_logic.sv
// ----------------------------------------------------------------------------
// tb_cond_logic -- directed bench for cond_logic with a behavioural model.
// The model tracks flags, memory-stage intents and the number of pipeline
// advances still to be squashed; a negedge process compares every cycle.
// ----------------------------------------------------------------------------
module tb_cond_logic;

    localparam int SLOTS = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       en, flush, InstrValid, CondEx, PCS, RegW, MemW, NoWrite;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic [3:0] Flags;
    logic       PCSrcM, RegWriteM, MemWriteM, Squash;

    int checks   = 0;
    int failures = 0;

    cond_logic #(.SHADOW_SLOTS(SLOTS)) dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush),
        .InstrValid(InstrValid), .CondEx(CondEx), .ALUFlags(ALUFlags),
        .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
        .Flags(Flags), .PCSrcM(PCSrcM), .RegWriteM(RegWriteM),
        .MemWriteM(MemWriteM), .Squash(Squash)
    );

    always #5 clk = ~clk;

    // ---- behavioural model --------------------------------------------------
    logic [3:0] m_flags = 4'b0;
    logic       m_pcs = 1'b0, m_regw = 1'b0, m_memw = 1'b0;
    int         m_left = 0;   // pipeline advances still to be killed
    logic       m_kill, m_exec;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_flags = 4'b0; m_pcs = 0; m_regw = 0; m_memw = 0; m_left = 0;
        end else begin
            m_kill = (m_left > 0);
            m_exec = InstrValid && CondEx && !m_kill;
            if (flush) begin
                m_pcs = 0; m_regw = 0; m_memw = 0; m_left = 0;
            end else if (en) begin
                if (m_exec && FlagW[1]) m_flags[3:2] = ALUFlags[3:2];
                if (m_exec && FlagW[0]) m_flags[1:0] = ALUFlags[1:0];
                m_pcs  = m_exec && PCS;
                m_regw = m_exec && RegW && !NoWrite;
                m_memw = m_exec && MemW;
                if (m_kill) m_left = m_left - 1;
                else if (m_exec && PCS) m_left = SLOTS;
            end
        end
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        chk("model_Flags", Flags, m_flags);
        chk("model_PCSrcM", {3'b0, PCSrcM}, {3'b0, m_pcs});
        chk("model_RegWriteM", {3'b0, RegWriteM}, {3'b0, m_regw});
        chk("model_MemWriteM", {3'b0, MemWriteM}, {3'b0, m_memw});
        chk("model_Squash", {3'b0, Squash}, {3'b0, (m_left > 0)});
    end

    task automatic drive(input logic iv, input logic cx, input logic [3:0] af,
                         input logic [1:0] fw, input logic pcs, input logic rw,
                         input logic mw, input logic nw, input logic e, input logic fl);
        InstrValid = iv; CondEx = cx; ALUFlags = af; FlagW = fw; PCS = pcs;
        RegW = rw; MemW = mw; NoWrite = nw; en = e; flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 0, 4'b0, 2'b00, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        chk("rst_Flags", Flags, 4'b0000);
        chk("rst_Squash", {3'b0, Squash}, 4'b0);
        chk("rst_RegWriteM", {3'b0, RegWriteM}, 4'b0);
        reset = 1'b1;

        // Flag register: full and half writes.
        drive(1, 1, 4'b0110, 2'b11, 0, 0, 0, 0, 1, 0); tick();
        chk("flags_full", Flags, 4'b0110);
        drive(1, 1, 4'b1001, 2'b10, 0, 0, 0, 0, 1, 0); tick();
        chk("flags_nz_only", Flags, 4'b1010);

        // Failed condition suppresses everything.
        drive(1, 0, 4'b1111, 2'b11, 0, 1, 1, 0, 1, 0); tick();
        chk("condfail_RegW", {3'b0, RegWriteM}, 4'b0);
        chk("condfail_MemW", {3'b0, MemWriteM}, 4'b0);
        chk("condfail_Flags", Flags, 4'b1010);

        // Compare-type instruction never writes the register file.
        drive(1, 1, 4'b0000, 2'b00, 0, 1, 0, 1, 1, 0); tick();
        chk("nowrite_RegW", {3'b0, RegWriteM}, 4'b0);
        drive(1, 1, 4'b0000, 2'b00, 0, 1, 1, 0, 1, 0); tick();
        chk("exec_RegW", {3'b0, RegWriteM}, 4'b1);
        chk("exec_MemW", {3'b0, MemWriteM}, 4'b1);

        // Taken branch followed by a two-advance shadow with a stall inside.
        drive(1, 1, 4'b0000, 2'b00, 1, 0, 0, 0, 1, 0); tick();
        chk("br_PCSrcM", {3'b0, PCSrcM}, 4'b1);
        chk("br_Squash", {3'b0, Squash}, 4'b1);
        drive(1, 1, 4'b1111, 2'b11, 1, 1, 1, 0, 1, 0); tick();
        chk("sh1_RegW", {3'b0, RegWriteM}, 4'b0);
        chk("sh1_PCSrcM", {3'b0, PCSrcM}, 4'b0);
        chk("sh1_Flags", Flags, 4'b1010);
        chk("sh1_Squash", {3'b0, Squash}, 4'b1);
        drive(1, 1, 4'b0000, 2'b00, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_Squash", {3'b0, Squash}, 4'b1);
        end
        drive(1, 1, 4'b0000, 2'b00, 0, 1, 0, 0, 1, 0); tick();
        chk("sh2_RegW", {3'b0, RegWriteM}, 4'b0);
        chk("sh2_Squash_done", {3'b0, Squash}, 4'b0);
        tick();
        chk("third_RegW", {3'b0, RegWriteM}, 4'b1);

        // Flush with a taken branch while stalled: flush wins.
        drive(1, 1, 4'b1111, 2'b11, 1, 1, 1, 0, 0, 1); tick();
        chk("flush_PCSrcM", {3'b0, PCSrcM}, 4'b0);
        chk("flush_RegW", {3'b0, RegWriteM}, 4'b0);
        chk("flush_Squash", {3'b0, Squash}, 4'b0);
        chk("flush_Flags", Flags, 4'b1010);

        // Asynchronous reset in the middle of a shadow.
        drive(1, 1, 4'b0000, 2'b00, 1, 0, 0, 0, 1, 0); tick();
        chk("br2_Squash", {3'b0, Squash}, 4'b1);
        #2 reset = 1'b0;
        #1;
        chk("arst_Flags", Flags, 4'b0000);
        chk("arst_PCSrcM", {3'b0, PCSrcM}, 4'b0);
        chk("arst_Squash", {3'b0, Squash}, 4'b0);
        tick();
        reset = 1'b1;
        drive(1, 1, 4'b0000, 2'b00, 0, 1, 0, 0, 1, 0); tick();
        chk("post_rst_RegW", {3'b0, RegWriteM}, 4'b1);
        chk("post_rst_Squash", {3'b0, Squash}, 4'b0);

        // Bubble registers nothing.
        drive(0, 1, 4'b1111, 2'b11, 1, 1, 1, 0, 1, 0); tick();
        chk("bubble_RegW", {3'b0, RegWriteM}, 4'b0);
        chk("bubble_Flags", Flags, 4'b0000);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
